tff_counter: RTL and testbench

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_counter.sv | 145 ++++++++++++++
 tb/tb_tff_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// ============================================================================
// Module   : tff_counter
// Summary  : Up/down counter built from per-bit T flip-flops, falling-edge
//            clocked, with clamped parallel load, wrap/saturate limits,
//            combinational terminal count and a one-cycle limit pulse.
//            Optional toggle-mask output: TFF_COUNTER_TOGGLE_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
    ,
    output logic [WIDTH-1:0] tog
`endif
);

    localparam logic [WIDTH-1:0] C_MAX  = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;

    logic [WIDTH-1:0] w_chain_up;
    logic [WIDTH-1:0] w_chain_dn;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_t;
    logic             w_use_target;
    logic             w_at_max;
    logic             w_above_max;
    logic             w_at_zero;
    logic             w_tc;

    // Classic synchronous T-counter enables: a bit toggles when every lower
    // bit is 1 (counting up) or every lower bit is 0 (counting down).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            if (gi == 0) begin : g_lsb
                assign w_chain_up[gi] = 1'b1;
                assign w_chain_dn[gi] = 1'b1;
            end else begin : g_upper
                assign w_chain_up[gi] = w_chain_up[gi-1] &  r_q[gi-1];
                assign w_chain_dn[gi] = w_chain_dn[gi-1] & ~r_q[gi-1];
            end
        end
    endgenerate

    assign w_at_max    = (r_q == C_MAX);
    assign w_above_max = (r_q >  C_MAX);
    assign w_at_zero   = (r_q == C_ZERO);
    assign w_tc        = en & ((up & w_at_max) | (~up & w_at_zero));

    // Loads and limit cases jump to an explicit value; the toggle mask is
    // then the XOR of the present and target values.
    always_comb begin
        w_target     = r_q;
        w_use_target = 1'b0;
        if (load) begin
            w_use_target = 1'b1;
            w_target     = (din > C_MAX) ? C_MAX : din;
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
                    w_use_target = 1'b1;
                    w_target     = (SATURATE != 0) ? r_q : C_ZERO;
                end else if (w_above_max) begin
                    w_use_target = 1'b1;
                    w_target     = C_ZERO;
                end
            end else begin
                if (w_at_zero) begin
                    w_use_target = 1'b1;
                    w_target     = (SATURATE != 0) ? r_q : C_MAX;
                end else if (w_above_max) begin
                    w_use_target = 1'b1;
                    w_target     = C_MAX;
                end
            end
        end
    end

    always_comb begin
        w_t = '0;
        if (w_use_target) begin
            w_t = r_q ^ w_target;
        end else if (en) begin
            w_t = up ? w_chain_up : w_chain_dn;
        end
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_t[i]) begin
                    r_q[i] <= ~r_q[i];
                end
            end
        end
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_tc & ~load;
        end
    end

`ifdef TFF_COUNTER_TOGGLE_OUT_EN
    logic [WIDTH-1:0] r_tog;

    always_ff @(negedge clk) begin
        if (clr) begin
            r_tog <= '0;
        end else begin
            r_tog <= w_t;
        end
    end

    assign tog = r_tog;
`endif

    assign q   = r_q;
    assign tc  = w_tc;
    assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_tff_counter.sv
// ============================================================================
// Module   : tb_tff_counter
// Summary  : Directed/random bench for tff_counter in three configurations,
//            checked against a behavioural model through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tff_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b0;
    logic       up  = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;

    logic [3:0] dq  [3];
    logic       dtc [3];
    logic       dov [3];
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
    logic [3:0] dtg [3];
`endif

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0)) u0 (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .q(dq[0]), .tc(dtc[0]), .ovf(dov[0])
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
        , .tog(dtg[0])
`endif
    );

    tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u1 (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .q(dq[1]), .tc(dtc[1]), .ovf(dov[1])
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
        , .tog(dtg[1])
`endif
    );

    tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u2 (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .q(dq[2]), .tc(dtc[2]), .ovf(dov[2])
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
        , .tog(dtg[2])
`endif
    );

    typedef struct {
        int         k;
        logic [3:0] q;
        logic       ovf;
        logic [3:0] tg;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   maxv[3] = '{15, 9, 9};
    int   satv[3] = '{0, 1, 0};
    int   mq[3]   = '{0, 0, 0};
    bit   mvalid  = 1'b0;

    task automatic check(input string tag, input int k,
                         input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s[%0d] got=%0h want=%0h", tag, k, obs, expv);
        end
    endtask

    // One falling edge: drive at the rising edge, check tc, push the model's
    // prediction, then pop and compare just after the falling edge.
    task automatic step(input logic c, input logic ld, input logic e,
                        input logic u, input logic [3:0] d);
        @(posedge clk);
        clr = c; load = ld; en = e; up = u; din = d;
        #1;
        for (int k = 0; k < 3; k++) begin
            int   nq;
            logic mtc;
            exp_t x;
            mtc = e && ((u && mq[k] == maxv[k]) || (!u && mq[k] == 0));
            if (mvalid) begin
                check("tc", k, 16'(dtc[k]), 16'(mtc));
                if (c) check("q_hold", k, 16'(dq[k]), 16'(mq[k]));
            end
            if (c) begin
                nq = 0;
            end else if (ld) begin
                nq = (int'(d) > maxv[k]) ? maxv[k] : int'(d);
            end else if (e && u) begin
                if (mq[k] == maxv[k])     nq = (satv[k] != 0) ? mq[k] : 0;
                else if (mq[k] > maxv[k]) nq = 0;
                else                      nq = mq[k] + 1;
            end else if (e) begin
                if (mq[k] == 0)           nq = (satv[k] != 0) ? 0 : maxv[k];
                else if (mq[k] > maxv[k]) nq = maxv[k];
                else                      nq = mq[k] - 1;
            end else begin
                nq = mq[k];
            end
            x.k   = k;
            x.q   = 4'(nq);
            x.ovf = mtc && !c && !ld;
            x.tg  = c ? 4'd0 : (4'(mq[k]) ^ 4'(nq));
            sb.push_back(x);
            mq[k] = nq;
        end
        if (c) mvalid = 1'b1;
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("q", x.k, 16'(dq[x.k]), 16'(x.q));
            check("ovf", x.k, 16'(dov[x.k]), 16'(x.ovf));
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
            check("tog", x.k, 16'(dtg[x.k]), 16'(x.tg));
`endif
        end
    endtask

    initial begin
        // reset
        step(1, 0, 0, 1, 4'd0);
        for (int k = 0; k < 3; k++) check("rst_q", k, 16'(dq[k]), 16'd0);

        // full-range count up with wrap
        for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 4'd0);
        check("wrap_q", 0, 16'(dq[0]), 16'd0);
        check("wrap_ovf", 0, 16'(dov[0]), 16'd1);
        step(0, 0, 1, 1, 4'd0);
        check("wrap_ovf_once", 0, 16'(dov[0]), 16'd0);

        // saturating up from 7
        step(0, 1, 0, 1, 4'd7);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 4'd0);
        check("sat_q", 1, 16'(dq[1]), 16'd9);
        check("sat_ovf", 1, 16'(dov[1]), 16'd1);

        // wrapping down from 0 to MAX_VAL
        step(0, 1, 0, 0, 4'd0);
        step(0, 0, 1, 0, 4'd0);
        check("dn_wrap_q", 2, 16'(dq[2]), 16'd9);
        check("dn_wrap_ovf", 2, 16'(dov[2]), 16'd1);
        step(0, 0, 1, 0, 4'd0);
        check("dn_q", 2, 16'(dq[2]), 16'd8);
        check("dn_ovf", 2, 16'(dov[2]), 16'd0);

        // clr beats load
        step(1, 1, 1, 1, 4'd5);
        check("clr_ld_q", 0, 16'(dq[0]), 16'd0);
        check("clr_ld_ovf", 0, 16'(dov[0]), 16'd0);

        // clamped load, then load beats a terminal-count increment
        step(0, 1, 0, 1, 4'd14);
        check("clamp_q", 1, 16'(dq[1]), 16'd9);
        check("noclamp_q", 0, 16'(dq[0]), 16'd14);
        step(0, 1, 1, 1, 4'd4);
        check("ld_tc_q", 2, 16'(dq[2]), 16'd4);
        check("ld_tc_ovf", 2, 16'(dov[2]), 16'd0);

        // toggle mask on 7 -> 8, then hold
        step(0, 1, 0, 1, 4'd7);
        step(0, 0, 1, 1, 4'd0);
        check("q_7to8", 0, 16'(dq[0]), 16'd8);
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
        check("tog_7to8", 0, 16'(dtg[0]), 16'hF);
        step(0, 0, 0, 1, 4'd0);
        check("tog_hold", 0, 16'(dtg[0]), 16'h0);
`endif

        // random mix, direction changes on any cycle
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r < 4, (r >= 4) && (r < 14), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
